// File: rtl/mindy_merge_if.sv
// rtl/mindy_merge_if.sv - stream bundle for mindy_merge: metadata in, frame data in, merged out
// Optional AXIS_OUT_TLAST exists only when MINDY_MERGE_TLAST_EN is defined.
interface mindy_merge_if #(
  parameter int DATA_WBITS = 512
);
  logic [DATA_WBITS-1:0] AXIS_MD_TDATA;
  logic                  AXIS_MD_TVALID;
  logic                  AXIS_MD_TREADY;
  logic [DATA_WBITS-1:0] AXIS_FD_TDATA;
  logic                  AXIS_FD_TVALID;
  logic                  AXIS_FD_TREADY;
  logic [DATA_WBITS-1:0] AXIS_OUT_TDATA;
  logic                  AXIS_OUT_TVALID;
  logic                  AXIS_OUT_TREADY;
`ifdef MINDY_MERGE_TLAST_EN
  logic                  AXIS_OUT_TLAST;
`endif

  modport slave (
    input  AXIS_MD_TDATA, AXIS_MD_TVALID,
    output AXIS_MD_TREADY,
    input  AXIS_FD_TDATA, AXIS_FD_TVALID,
    output AXIS_FD_TREADY,
    output AXIS_OUT_TDATA, AXIS_OUT_TVALID,
`ifdef MINDY_MERGE_TLAST_EN
    output AXIS_OUT_TLAST,
`endif
    input  AXIS_OUT_TREADY
  );

  modport master (
    output AXIS_MD_TDATA, AXIS_MD_TVALID,
    input  AXIS_MD_TREADY,
    output AXIS_FD_TDATA, AXIS_FD_TVALID,
    input  AXIS_FD_TREADY,
    input  AXIS_OUT_TDATA, AXIS_OUT_TVALID,
`ifdef MINDY_MERGE_TLAST_EN
    input  AXIS_OUT_TLAST,
`endif
    output AXIS_OUT_TREADY
  );
endinterface

// File: rtl/mindy_merge.sv
// rtl/mindy_merge.sv - merges MD_BEATS metadata beats then FRAME_SIZE bytes of frame data per phase
// Optional AXIS_OUT_TLAST marks the last beat of each phase when MINDY_MERGE_TLAST_EN is defined.
module mindy_merge #(
  parameter int DATA_WBITS = 512,
  parameter int MD_BEATS   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] FRAME_SIZE,
  mindy_merge_if.slave bus
);
  localparam logic [0:0] S_MD = 1'b0;
  localparam logic [0:0] S_FD = 1'b1;
  localparam int BYTE_SHIFT = $clog2(DATA_WBITS / 8);

  logic [0:0]            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           size_q, size_d;
  logic                  run_q;
  logic [DATA_WBITS-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  sel_tready;
  logic                  md_acc, fd_acc, in_acc;
  logic                  last_md, last_fd;
  logic [31:0]           fd_beats;
  logic [DATA_WBITS-1:0] in_data;

  // run_q keeps both TREADYs low while reset is held and for the release cycle
  assign sel_tready          = run_q & (~tvalid_q | bus.AXIS_OUT_TREADY);
  assign bus.AXIS_MD_TREADY  = sel_tready & (state_q == S_MD);
  assign bus.AXIS_FD_TREADY  = sel_tready & (state_q == S_FD);
  assign md_acc              = bus.AXIS_MD_TVALID & bus.AXIS_MD_TREADY;
  assign fd_acc              = bus.AXIS_FD_TVALID & bus.AXIS_FD_TREADY;
  assign in_acc              = md_acc | fd_acc;
  assign in_data             = (state_q == S_MD) ? bus.AXIS_MD_TDATA : bus.AXIS_FD_TDATA;
  assign bus.AXIS_OUT_TDATA  = tdata_q;
  assign bus.AXIS_OUT_TVALID = tvalid_q;

  // size_d already reflects a size captured this cycle, so the phase length is known on beat 0
  always_comb begin
    size_d = size_q;
    if (md_acc && cnt_q == 32'd0) size_d = FRAME_SIZE;
  end

  assign fd_beats = size_d >> BYTE_SHIFT;
  assign last_md  = md_acc && (cnt_q == 32'(MD_BEATS - 1));
  assign last_fd  = fd_acc && (cnt_q == fd_beats - 32'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (last_md) begin
      cnt_d = 32'd0;
      if (fd_beats != 32'd0) state_d = S_FD;
    end else if (last_fd) begin
      cnt_d   = 32'd0;
      state_d = S_MD;
    end else if (in_acc) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_MD;
      cnt_q    <= 32'd0;
      size_q   <= 32'd0;
      run_q    <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      if (in_acc)                    tvalid_q <= 1'b1;
      else if (bus.AXIS_OUT_TREADY)  tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc) tdata_q <= in_data;
  end

`ifdef MINDY_MERGE_TLAST_EN
  logic tlast_q;
  logic phase_end;

  assign phase_end          = (last_md && fd_beats == 32'd0) || last_fd;
  assign bus.AXIS_OUT_TLAST = tlast_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     tlast_q <= 1'b0;
    else if (in_acc) tlast_q <= phase_end;
  end
`endif
endmodule

// File: tb/tb_mindy_merge.sv
// tb/tb_mindy_merge.sv - directed self-checking bench for mindy_merge
// Sources are always valid and tag each beat with stream id and sequence number.
module tb_mindy_merge;
  localparam int DW = 512;
  localparam int MD = 2;
  localparam logic [15:0] TAG_MD = 16'h4D44;
  localparam logic [15:0] TAG_FD = 16'h4644;

  logic        clk;
  logic        resetn;
  logic [31:0] frame_size;

  mindy_merge_if #(.DATA_WBITS(DW)) ifc ();

  mindy_merge #(.DATA_WBITS(DW), .MD_BEATS(MD)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .FRAME_SIZE (frame_size),
    .bus        (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int md_seq, fd_seq, md_exp, fd_exp, pos, fd_ph, beats_out;
  bit bp, thr_check, prev_stall, tv_expect, first_acc_seen, tv_seen, fd_ready_seen;
  logic [DW-1:0] prev_data;
  logic          prev_tlast;
  logic [15:0]   first_tag;

  function automatic logic [DW-1:0] mk(input logic [15:0] tag, input int seq);
    return (DW'(tag) << (DW - 16)) | DW'(seq);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat();
    int plen;
    logic [DW-1:0] exp;
    plen = MD + fd_ph;
    if (pos < MD) begin exp = mk(TAG_MD, md_exp); md_exp++; end
    else          begin exp = mk(TAG_FD, fd_exp); fd_exp++; end
    chk("out_data", ifc.AXIS_OUT_TDATA, exp);
`ifdef MINDY_MERGE_TLAST_EN
    chk("out_tlast", DW'(ifc.AXIS_OUT_TLAST), DW'(pos == plen - 1));
`endif
    pos = (pos == plen - 1) ? 0 : pos + 1;
    beats_out++;
    if (beats_out == 1) first_tag = ifc.AXIS_OUT_TDATA[DW-1 -: 16];
  endtask

  // One clock: sample at the falling edge, update sources just after the rising edge
  task automatic cyc();
    bit md_acc, fd_acc;
    @(negedge clk);
    md_acc = ifc.AXIS_MD_TVALID && ifc.AXIS_MD_TREADY;
    fd_acc = ifc.AXIS_FD_TVALID && ifc.AXIS_FD_TREADY;
    if (ifc.AXIS_FD_TREADY) fd_ready_seen = 1'b1;
    if (tv_expect) begin
      chk("first_tvalid_latency", DW'(ifc.AXIS_OUT_TVALID), DW'(1));
      tv_expect = 1'b0;
    end
    if (md_acc && !first_acc_seen) begin
      first_acc_seen = 1'b1;
      tv_expect = 1'b1;
    end
    if (thr_check && tv_seen) chk("throughput_tvalid", DW'(ifc.AXIS_OUT_TVALID), DW'(1));
    if (ifc.AXIS_OUT_TVALID) tv_seen = 1'b1;
    if (prev_stall) begin
      chk("stall_tvalid", DW'(ifc.AXIS_OUT_TVALID), DW'(1));
      chk("stall_tdata", ifc.AXIS_OUT_TDATA, prev_data);
`ifdef MINDY_MERGE_TLAST_EN
      chk("stall_tlast", DW'(ifc.AXIS_OUT_TLAST), DW'(prev_tlast));
`endif
    end
    if (ifc.AXIS_OUT_TVALID && ifc.AXIS_OUT_TREADY) check_beat();
    prev_stall = ifc.AXIS_OUT_TVALID && !ifc.AXIS_OUT_TREADY;
    prev_data  = ifc.AXIS_OUT_TDATA;
`ifdef MINDY_MERGE_TLAST_EN
    prev_tlast = ifc.AXIS_OUT_TLAST;
`endif
    @(posedge clk);
    #1;
    if (md_acc) begin md_seq++; ifc.AXIS_MD_TDATA = mk(TAG_MD, md_seq); end
    if (fd_acc) begin fd_seq++; ifc.AXIS_FD_TDATA = mk(TAG_FD, fd_seq); end
    ifc.AXIS_OUT_TREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Asserts reset right away, checks outputs cleared before the next edge, restarts the model
  task automatic do_reset(input int fs, input bit with_bp);
    resetn = 1'b0;
    #1;
    chk("rst_out_tvalid", DW'(ifc.AXIS_OUT_TVALID), DW'(0));
    chk("rst_md_tready", DW'(ifc.AXIS_MD_TREADY), DW'(0));
    chk("rst_fd_tready", DW'(ifc.AXIS_FD_TREADY), DW'(0));
`ifdef MINDY_MERGE_TLAST_EN
    chk("rst_tlast", DW'(ifc.AXIS_OUT_TLAST), DW'(0));
`endif
    repeat (2) @(posedge clk);
    frame_size = fs;
    md_seq = 0; fd_seq = 0; md_exp = 0; fd_exp = 0; pos = 0; beats_out = 0;
    fd_ph = fs >> 6;
    ifc.AXIS_MD_TDATA = mk(TAG_MD, 0);
    ifc.AXIS_FD_TDATA = mk(TAG_FD, 0);
    bp = with_bp;
    ifc.AXIS_OUT_TREADY = 1'b1;
    prev_stall = 0; tv_expect = 0; first_acc_seen = 0; tv_seen = 0; fd_ready_seen = 0;
    thr_check = 0; first_tag = 16'h0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b1;
    frame_size = 32'd256;
    ifc.AXIS_MD_TVALID = 1'b1;
    ifc.AXIS_FD_TVALID = 1'b1;
    ifc.AXIS_OUT_TREADY = 1'b1;
    ifc.AXIS_MD_TDATA = '0;
    ifc.AXIS_FD_TDATA = '0;
    @(posedge clk);
    #1;

    // 256 bytes: 2 MD + 4 FD per phase at full rate
    do_reset(256, 1'b0);
    thr_check = 1'b1;
    repeat (40) cyc();
    chk("fs256_beats_ge36", DW'(beats_out >= 36), DW'(1));
    chk("fs256_first_md", DW'(first_tag), DW'(TAG_MD));

    // 300 bytes truncates to 4 FD beats; the 5th waits behind the next MD pair
    do_reset(300, 1'b0);
    repeat (40) cyc();
    chk("fs300_beats_ge36", DW'(beats_out >= 36), DW'(1));

    // 32 bytes: metadata-only phases
    do_reset(32, 1'b0);
    repeat (30) cyc();
    chk("fs32_fd_tready_never", DW'(fd_ready_seen), DW'(0));
    chk("fs32_fd_not_consumed", DW'(fd_seq), DW'(0));
    chk("fs32_md_beats", DW'(beats_out >= 20), DW'(1));

    // 128 bytes with 50% backpressure for 100 phases of 4 beats
    do_reset(128, 1'b1);
    for (int i = 0; i < 5000 && beats_out < 400; i++) cyc();
    chk("bp_400_beats_done", DW'(beats_out >= 400), DW'(1));
    bp = 1'b0;

    // Reset pulsed right after the 3rd FD beat is accepted
    do_reset(256, 1'b0);
    for (int i = 0; i < 100 && fd_seq < 3; i++) cyc();
    chk("fd3_reached", DW'(fd_seq), DW'(3));
    do_reset(256, 1'b0);
    repeat (12) cyc();
    chk("post_rst_first_md", DW'(first_tag), DW'(TAG_MD));
    chk("post_rst_beats", DW'(beats_out >= 8), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
